// File: rtl/oport_credit_tracker.sv
`default_nettype none
// ============================================================================
// Module   : oport_credit_tracker
// Brief    : Output-side tracker of downstream VC credits, packet ownership,
//            per-port congestion level and sticky link-protocol errors.
// Revision : 1.0 - initial release
// ============================================================================
module oport_credit_tracker #(
  parameter int V           = 4,
  parameter int P           = 5,
  parameter int B           = 4,
  parameter int FPAY        = 32,
  parameter int CONGW       = 3,
  parameter int CONG_THRESH = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [P*(2+V+FPAY)-1:0]              flit_out_all,
  input  logic [P-1:0]                         flit_out_we_all,
  input  logic [P*V-1:0]                       credit_in_all,
  input  logic                                 err_clear,
  output logic [P*V*$clog2(B+1)-1:0]           ovc_credit_all,
  output logic [P*V-1:0]                       ovc_full_all,
  output logic [P*V-1:0]                       ovc_nearly_full_all,
  output logic [P*V-1:0]                       ovc_allocated_all,
  output logic [P*CONGW-1:0]                   congestion_out_all,
  output logic [P*V-1:0]                       err_underflow,
  output logic [P*V-1:0]                       err_overflow,
  output logic [P-1:0]                         err_proto
);

  localparam int              c_fw       = 2 + V + FPAY;
  localparam int              c_pv       = P * V;
  localparam int              c_bw       = $clog2(B + 1);
  localparam logic [c_bw-1:0] c_b_max    = c_bw'(B);
  localparam logic [c_bw-1:0] c_thr      = c_bw'(CONG_THRESH);
  localparam logic [c_bw-1:0] c_one      = c_bw'(1);
  localparam int              c_cong_sat = (1 << CONGW) - 1;

  // Packet-ownership FSM encoding (one FSM per OVC)
  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_busy = 1'b1;

  logic [P-1:0]    w_hdr;
  logic [P-1:0]    w_tail;
  logic [P-1:0]    w_vc_bad;
  logic [c_pv-1:0] w_dec;
  logic [c_pv-1:0] w_frame_err;
  logic [c_pv-1:0] w_cong_ovc;

  // --------------------------------------------------------------------------
  // Per-port flit decode, protocol error and congestion grading
  // --------------------------------------------------------------------------
  generate
    for (genvar gp = 0; gp < P; gp++) begin : g_port
      logic [V-1:0]       w_vc;
      logic               w_vc_onehot;
      logic               w_unused_payload;
      logic               w_proto_evt;
      logic               r_err_proto;
      logic [31:0]        w_cnt;
      logic [CONGW-1:0]   w_level;
      logic [CONGW-1:0]   r_level;

      assign w_vc             = flit_out_all[gp*c_fw + FPAY +: V];
      assign w_hdr[gp]        = flit_out_all[gp*c_fw + c_fw - 1];
      assign w_tail[gp]       = flit_out_all[gp*c_fw + c_fw - 2];
      assign w_unused_payload = ^flit_out_all[gp*c_fw +: FPAY];
      assign w_vc_onehot      = $onehot(w_vc);
      assign w_vc_bad[gp]     = flit_out_we_all[gp] & ~w_vc_onehot;

      // A malformed VC field suppresses every counter/FSM effect on the port
      assign w_dec[gp*V +: V] = (flit_out_we_all[gp] && w_vc_onehot) ? w_vc : '0;

      assign w_proto_evt = w_vc_bad[gp] | (|w_frame_err[gp*V +: V]);

      // Sticky protocol error; a new event wins over a clear
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_err_proto <= 1'b0;
        else        r_err_proto <= (r_err_proto & ~err_clear) | w_proto_evt;
      end

      // Count congested OVCs and saturate to the level width
      always_comb begin
        w_cnt = 32'd0;
        for (int k = 0; k < V; k++) begin
          if (w_cong_ovc[gp*V + k]) w_cnt = w_cnt + 32'd1;
        end
        w_level = (w_cnt > c_cong_sat) ? CONGW'(c_cong_sat) : w_cnt[CONGW-1:0];
      end

      // The level is graded from the registered credits, so it trails the
      // credit count by one cycle
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_level <= '0;
        else        r_level <= w_level;
      end

      assign err_proto[gp]                       = r_err_proto;
      assign congestion_out_all[gp*CONGW +: CONGW] = r_level;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Per-OVC credit counter, error flags and ownership FSM
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < c_pv; gi++) begin : g_ovc
      localparam int c_port = gi / V;

      logic [c_bw-1:0] r_credit;
      logic [c_bw-1:0] w_credit_nxt;
      logic            w_uf_evt;
      logic            w_of_evt;
      logic            r_err_uf;
      logic            r_err_of;
      logic [0:0]      r_state;
      logic [0:0]      w_state_nxt;
      logic            w_ferr;
      logic            w_alloc;

      // Credit next-state: simultaneous send and return cancel out
      always_comb begin
        w_credit_nxt = r_credit;
        w_uf_evt     = 1'b0;
        w_of_evt     = 1'b0;
        if (w_dec[gi] && !credit_in_all[gi]) begin
          if (r_credit == '0) w_uf_evt     = 1'b1;
          else                w_credit_nxt = r_credit - c_one;
        end else if (!w_dec[gi] && credit_in_all[gi]) begin
          if (r_credit == c_b_max) w_of_evt     = 1'b1;
          else                     w_credit_nxt = r_credit + c_one;
        end
      end

      // Credit register and sticky underflow/overflow flags
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_credit <= c_b_max;
          r_err_uf <= 1'b0;
          r_err_of <= 1'b0;
        end else begin
          r_credit <= w_credit_nxt;
          r_err_uf <= (r_err_uf & ~err_clear) | w_uf_evt;
          r_err_of <= (r_err_of & ~err_clear) | w_of_evt;
        end
      end

      // Ownership FSM state register
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
      end

      // Ownership FSM next state; framing violations leave the state alone
      always_comb begin
        w_state_nxt = r_state;
        w_ferr      = 1'b0;
        if (w_dec[gi]) begin
          case (r_state)
            c_st_idle: begin
              if (!w_hdr[c_port])      w_ferr      = 1'b1;
              else if (!w_tail[c_port]) w_state_nxt = c_st_busy;
            end
            c_st_busy: begin
              if (w_hdr[c_port])       w_ferr      = 1'b1;
              else if (w_tail[c_port]) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
          endcase
        end
      end

      // Ownership FSM outputs
      always_comb begin
        w_alloc = (r_state == c_st_busy);
      end

      assign w_frame_err[gi]                 = w_ferr;
      assign w_cong_ovc[gi]                  = (r_credit <= c_thr);
      assign ovc_credit_all[gi*c_bw +: c_bw] = r_credit;
      assign ovc_full_all[gi]                = (r_credit == '0);
      assign ovc_nearly_full_all[gi]         = (r_credit == c_one);
      assign ovc_allocated_all[gi]           = w_alloc;
      assign err_underflow[gi]               = r_err_uf;
      assign err_overflow[gi]                = r_err_of;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_oport_credit_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_oport_credit_tracker
// Brief    : Directed self-checking bench for oport_credit_tracker with a
//            behavioural credit/packet model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oport_credit_tracker;

  localparam int V    = 4;
  localparam int P    = 5;
  localparam int B    = 4;
  localparam int FPAY = 32;
  localparam int THR  = 1;
  localparam int FW   = 2 + V + FPAY;
  localparam int PV   = P * V;
  localparam int BW   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [P*FW-1:0]   flit_out_all;
  logic [P-1:0]      flit_out_we_all;
  logic [PV-1:0]     credit_in_all;
  logic              err_clear;

  logic [PV*BW-1:0]  ovc_credit_all,  c2_credit;
  logic [PV-1:0]     ovc_full_all,    c2_full;
  logic [PV-1:0]     ovc_nearly_full_all, c2_nf;
  logic [PV-1:0]     ovc_allocated_all,   c2_alloc;
  logic [P*3-1:0]    congestion_out_all;
  logic [P*2-1:0]    c2_cong;
  logic [PV-1:0]     err_underflow,   c2_uf;
  logic [PV-1:0]     err_overflow,    c2_of;
  logic [P-1:0]      err_proto,       c2_proto;

  oport_credit_tracker #(.V(V), .P(P), .B(B), .FPAY(FPAY), .CONGW(3), .CONG_THRESH(THR)) dut (
    .clk(clk), .reset(reset), .flit_out_all(flit_out_all), .flit_out_we_all(flit_out_we_all),
    .credit_in_all(credit_in_all), .err_clear(err_clear), .ovc_credit_all(ovc_credit_all),
    .ovc_full_all(ovc_full_all), .ovc_nearly_full_all(ovc_nearly_full_all),
    .ovc_allocated_all(ovc_allocated_all), .congestion_out_all(congestion_out_all),
    .err_underflow(err_underflow), .err_overflow(err_overflow), .err_proto(err_proto));

  oport_credit_tracker #(.V(V), .P(P), .B(B), .FPAY(FPAY), .CONGW(2), .CONG_THRESH(THR)) dut2 (
    .clk(clk), .reset(reset), .flit_out_all(flit_out_all), .flit_out_we_all(flit_out_we_all),
    .credit_in_all(credit_in_all), .err_clear(err_clear), .ovc_credit_all(c2_credit),
    .ovc_full_all(c2_full), .ovc_nearly_full_all(c2_nf),
    .ovc_allocated_all(c2_alloc), .congestion_out_all(c2_cong),
    .err_underflow(c2_uf), .err_overflow(c2_of), .err_proto(c2_proto));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model state
  int m_credit [PV];
  bit m_busy   [PV];
  bit m_uf     [PV];
  bit m_of     [PV];
  bit m_proto  [P];
  int m_cong   [P];
  int m_cong2  [P];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PV; i++) begin
      m_credit[i] = B; m_busy[i] = 0; m_uf[i] = 0; m_of[i] = 0;
    end
    for (int p = 0; p < P; p++) begin
      m_proto[p] = 0; m_cong[p] = 0; m_cong2[p] = 0;
    end
  endtask

  // One clock edge of the model, using the inputs present at that edge
  task automatic model_step();
    bit dec [PV];
    bit uf_ev [PV];
    bit of_ev [PV];
    bit pr_ev [P];
    for (int i = 0; i < PV; i++) begin dec[i] = 0; uf_ev[i] = 0; of_ev[i] = 0; end
    for (int p = 0; p < P; p++) begin
      int n;
      n = 0;
      for (int v = 0; v < V; v++) if (m_credit[p*V+v] <= THR) n++;
      m_cong[p]  = sat(n, 3);
      m_cong2[p] = sat(n, 2);
      pr_ev[p] = 0;
    end
    for (int p = 0; p < P; p++) begin
      if (flit_out_we_all[p]) begin
        logic [FW-1:0] f;
        logic [V-1:0]  vc;
        bit hdr, tail;
        f    = flit_out_all[p*FW +: FW];
        hdr  = f[FW-1];
        tail = f[FW-2];
        vc   = f[FPAY +: V];
        if ($countones(vc) != 1) pr_ev[p] = 1;
        else begin
          int idx;
          idx = 0;
          for (int v = 0; v < V; v++) if (vc[v]) idx = p*V + v;
          dec[idx] = 1;
          if (!m_busy[idx]) begin
            if (!hdr) pr_ev[p] = 1;
            else if (!tail) m_busy[idx] = 1;
          end else begin
            if (hdr) pr_ev[p] = 1;
            else if (tail) m_busy[idx] = 0;
          end
        end
      end
    end
    for (int i = 0; i < PV; i++) begin
      if (dec[i] && !credit_in_all[i]) begin
        if (m_credit[i] == 0) uf_ev[i] = 1; else m_credit[i]--;
      end else if (!dec[i] && credit_in_all[i]) begin
        if (m_credit[i] == B) of_ev[i] = 1; else m_credit[i]++;
      end
      m_uf[i] = (m_uf[i] && !err_clear) || uf_ev[i];
      m_of[i] = (m_of[i] && !err_clear) || of_ev[i];
    end
    for (int p = 0; p < P; p++) m_proto[p] = (m_proto[p] && !err_clear) || pr_ev[p];
  endtask

  task automatic check_all();
    logic [PV*BW-1:0] e_cr;
    logic [PV-1:0]    e_full, e_nf, e_al, e_uf, e_of;
    logic [P-1:0]     e_pr;
    logic [P*3-1:0]   e_cg;
    logic [P*2-1:0]   e_cg2;
    for (int i = 0; i < PV; i++) begin
      e_cr[i*BW +: BW] = BW'(m_credit[i]);
      e_full[i] = (m_credit[i] == 0);
      e_nf[i]   = (m_credit[i] == 1);
      e_al[i]   = m_busy[i];
      e_uf[i]   = m_uf[i];
      e_of[i]   = m_of[i];
    end
    for (int p = 0; p < P; p++) begin
      e_pr[p]        = m_proto[p];
      e_cg[p*3 +: 3] = 3'(m_cong[p]);
      e_cg2[p*2 +: 2] = 2'(m_cong2[p]);
    end
    check("credit",      ovc_credit_all,      e_cr);
    check("full",        ovc_full_all,        e_full);
    check("nearly_full", ovc_nearly_full_all, e_nf);
    check("allocated",   ovc_allocated_all,   e_al);
    check("congestion",  congestion_out_all,  e_cg);
    check("underflow",   err_underflow,       e_uf);
    check("overflow",    err_overflow,        e_of);
    check("proto",       err_proto,           e_pr);
    check("congestion_w2", c2_cong,           e_cg2);
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) check_all();
  end

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flit_out_all    = '0;
    flit_out_we_all = '0;
    credit_in_all   = '0;
    err_clear       = 1'b0;
  endtask

  // Drive one cycle: optional flit on port p (p<0 means none), credits, clear
  task automatic send(input int p, input bit hdr, input bit tail, input logic [V-1:0] vc,
                      input logic [PV-1:0] cr, input bit clr);
    idle_inputs();
    if (p >= 0) begin
      flit_out_all[p*FW +: FW] = {hdr, tail, vc, FPAY'($urandom)};
      flit_out_we_all[p]       = 1'b1;
    end
    credit_in_all = cr;
    err_clear     = clr;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    chk_en = 1'b1;

    // Reset then idle
    repeat (5) send(-1, 0, 0, 4'b0000, '0, 0);
    check("rst_credit6", ovc_credit_all[6*BW +: BW], 3'd4);
    check("rst_full",    ovc_full_all, '0);
    check("rst_cong",    congestion_out_all, '0);
    check("rst_errs",    {err_underflow, err_overflow, err_proto}, '0);

    // Port 1 VC2 packet of four flits
    send(1, 1, 0, 4'b0100, '0, 0);
    check("p1_hdr_credit", ovc_credit_all[6*BW +: BW], 3'd3);
    check("p1_hdr_alloc",  ovc_allocated_all[6], 1'b1);
    send(1, 0, 0, 4'b0100, '0, 0);
    send(1, 0, 0, 4'b0100, '0, 0);
    check("p1_credit1",  ovc_credit_all[6*BW +: BW], 3'd1);
    check("p1_nfull",    ovc_nearly_full_all[6], 1'b1);
    check("p1_cong_lag", congestion_out_all[3 +: 3], 3'd0);
    send(1, 0, 1, 4'b0100, '0, 0);
    check("p1_credit0",  ovc_credit_all[6*BW +: BW], 3'd0);
    check("p1_full",     ovc_full_all[6], 1'b1);
    check("p1_tail_alloc", ovc_allocated_all[6], 1'b0);
    check("p1_cong",     congestion_out_all[3 +: 3], 3'd1);

    // Underflow, clear, and clear colliding with a new underflow
    send(1, 1, 1, 4'b0100, '0, 0);
    check("uf_credit", ovc_credit_all[6*BW +: BW], 3'd0);
    check("uf_set",    err_underflow[6], 1'b1);
    send(-1, 0, 0, 4'b0000, '0, 1);
    check("uf_clear",  err_underflow[6], 1'b0);
    send(1, 1, 1, 4'b0100, '0, 1);
    check("uf_set_wins", err_underflow[6], 1'b1);

    // Port 0 VC0: simultaneous send/return, then overflow
    send(0, 1, 0, 4'b0001, '0, 0);
    send(0, 0, 0, 4'b0001, '0, 0);
    send(0, 0, 0, 4'b0001, 20'h00001, 0);
    check("p0_same_cycle", ovc_credit_all[0 +: BW], 3'd2);
    check("p0_no_err",     {err_underflow[0], err_overflow[0]}, 2'b00);
    send(0, 0, 1, 4'b0001, 20'h00001, 0);
    send(-1, 0, 0, 4'b0000, 20'h00001, 0);
    send(-1, 0, 0, 4'b0000, 20'h00001, 0);
    check("p0_full_credit", ovc_credit_all[0 +: BW], 3'd4);
    send(-1, 0, 0, 4'b0000, 20'h00001, 0);
    check("of_credit", ovc_credit_all[0 +: BW], 3'd4);
    check("of_set",    err_overflow[0], 1'b1);

    // Port 3 malformed VC fields
    send(3, 1, 0, 4'b0110, '0, 0);
    send(3, 1, 0, 4'b0000, '0, 0);
    check("p3_proto",   err_proto[3], 1'b1);
    check("p3_credits", ovc_credit_all[12*BW +: 4*BW], 12'h924);
    send(-1, 0, 0, 4'b0000, '0, 1);
    check("p3_clear",   err_proto[3], 1'b0);
    // Header into a BUSY OVC
    send(3, 1, 0, 4'b0001, '0, 0);
    send(3, 1, 0, 4'b0001, '0, 0);
    check("p3_hdr_busy_err",   err_proto[3], 1'b1);
    check("p3_hdr_busy_alloc", ovc_allocated_all[12], 1'b1);
    send(3, 0, 1, 4'b0001, '0, 0);
    check("p3_tail_alloc", ovc_allocated_all[12], 1'b0);

    // Port 4: drive every VC down to credit 1
    for (int r = 0; r < 3; r++)
      for (int v = 0; v < V; v++) send(4, 1, 1, V'(1 << v), '0, 0);
    send(-1, 0, 0, 4'b0000, '0, 0);
    check("p4_credits", ovc_credit_all[16*BW +: 4*BW], 12'h249);
    check("p4_cong_w3", congestion_out_all[12 +: 3], 3'd4);
    check("p4_cong_w2", c2_cong[8 +: 2], 2'd3);

    // Asynchronous reset in the middle of a packet
    send(2, 1, 0, 4'b0010, '0, 0);
    check("p2_alloc", ovc_allocated_all[9], 1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_alloc",  ovc_allocated_all, '0);
    check("async_credit", ovc_credit_all, {PV{3'd4}});
    check("async_cong",   congestion_out_all, '0);
    tick();
    reset = 1'b1;
    repeat (3) send(-1, 0, 0, 4'b0000, '0, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
